// File: rtl/wb_pkg.sv
// Shared Wishbone slave types: bus widths and responder FSM state encoding.
// Latency: n/a (types only).
// Backpressure: n/a (types only).
package wb_pkg;

  localparam int WB_DATA_W = 32;
  localparam int WB_SEL_W  = 4;

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    RESP
  } wb_slv_state_t;

endpackage

// File: rtl/sram_bytewe.sv
// Single-port word SRAM with per-byte write enables; kept separate so a macro can replace it.
// Latency: write commits on the rising edge, read is combinational from addr.
// Backpressure: none, accepts a write every cycle.
//
// Ports: clk; we[3:0] byte-lane write enables; addr word address;
//        wdata write word; rdata word currently at addr.
module sram_bytewe
  import wb_pkg::*;
#(
  parameter int ADDR_WIDTH = 10
) (
  input  logic                  clk,
  input  logic [WB_SEL_W-1:0]   we,
  input  logic [ADDR_WIDTH-1:0] addr,
  input  logic [WB_DATA_W-1:0]  wdata,
  output logic [WB_DATA_W-1:0]  rdata
);

  logic [WB_DATA_W-1:0] mem [2**ADDR_WIDTH];

  // Storage is deliberately not reset.
  always_ff @(posedge clk) begin
    for (int b = 0; b < WB_SEL_W; b++) begin
      if (we[b]) begin
        mem[addr][8*b +: 8] <= wdata[8*b +: 8];
      end
    end
  end

  assign rdata = mem[addr];

endmodule

// File: rtl/wb_sram_slave.sv
// Wishbone classic responder over an on-chip SRAM, with err on misaligned/out-of-range access.
// Latency: request sampled at edge N, ack/err for one cycle in cycle N+1+LATENCY.
// Backpressure: one access in flight; inputs ignored outside IDLE, cyc drop during WAIT aborts.
//
// Ports: clk, rst_i (async, active high); wb_cyc_i/wb_stb_i/wb_we_i request;
//        wb_adr_i byte address; wb_sel_i byte lanes; wb_dat_i write data;
//        wb_dat_o read data (valid with ack); wb_ack_o/wb_err_o single-cycle termination.
module wb_sram_slave
  import wb_pkg::*;
#(
  parameter int          ADDR_WIDTH = 10,
  parameter logic [31:0] BASE_ADDR  = 32'h0000_0000,
  parameter int          LATENCY    = 0
) (
  input  logic                 clk,
  input  logic                 rst_i,
  input  logic                 wb_cyc_i,
  input  logic                 wb_stb_i,
  input  logic                 wb_we_i,
  input  logic [31:0]          wb_adr_i,
  input  logic [WB_SEL_W-1:0]  wb_sel_i,
  input  logic [WB_DATA_W-1:0] wb_dat_i,
  output logic [WB_DATA_W-1:0] wb_dat_o,
  output logic                 wb_ack_o,
  output logic                 wb_err_o
);

  wb_slv_state_t state, state_nxt;
  logic [3:0]    cnt, cnt_nxt;

  logic [31:0]          adr_q;
  logic                 we_q;
  logic [WB_SEL_W-1:0]  sel_q;
  logic [WB_DATA_W-1:0] dat_q;
  logic                 err_q;

  logic                 req;
  logic                 enter_resp;
  logic [31:0]          src_adr;
  logic                 src_we;
  logic [WB_SEL_W-1:0]  src_sel;
  logic [WB_DATA_W-1:0] src_dat;
  logic [29:0]          word_off;
  logic                 src_err;
  logic [WB_SEL_W-1:0]  mem_we;
  logic [WB_DATA_W-1:0] mem_rdata;

  assign req = wb_cyc_i & wb_stb_i;

  // With zero wait states the memory write happens on the same edge that
  // samples the request, so in IDLE the live bus feeds decode and the SRAM;
  // otherwise the captured request does.
  assign src_adr = (state == IDLE) ? wb_adr_i : adr_q;
  assign src_we  = (state == IDLE) ? wb_we_i  : we_q;
  assign src_sel = (state == IDLE) ? wb_sel_i : sel_q;
  assign src_dat = (state == IDLE) ? wb_dat_i : dat_q;

  // Word offset from the region base; any bit above the array index means
  // out of range, including addresses below the base (they wrap high).
  assign word_off = src_adr[31:2] - BASE_ADDR[31:2];
  assign src_err  = (|src_adr[1:0]) | (|word_off[29:ADDR_WIDTH]);

  always_comb begin
    state_nxt  = state;
    cnt_nxt    = cnt;
    enter_resp = 1'b0;
    case (state)
      IDLE: begin
        if (req) begin
          if (LATENCY == 0) begin
            state_nxt  = RESP;
            enter_resp = 1'b1;
          end else begin
            state_nxt = WAIT;
            cnt_nxt   = 4'(LATENCY - 1);
          end
        end
      end
      WAIT: begin
        if (!wb_cyc_i) begin
          state_nxt = IDLE;
        end else if (cnt == 4'd0) begin
          state_nxt  = RESP;
          enter_resp = 1'b1;
        end else begin
          cnt_nxt = cnt - 4'd1;
        end
      end
      RESP:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst_i) begin
    if (rst_i) begin
      state <= IDLE;
      cnt   <= 4'd0;
      adr_q <= '0;
      we_q  <= 1'b0;
      sel_q <= '0;
      dat_q <= '0;
      err_q <= 1'b0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      if (state == IDLE && req) begin
        adr_q <= wb_adr_i;
        we_q  <= wb_we_i;
        sel_q <= wb_sel_i;
        dat_q <= wb_dat_i;
      end
      if (enter_resp) begin
        err_q <= src_err;
      end
    end
  end

  assign mem_we = (enter_resp && src_we && !src_err) ? src_sel : '0;

  sram_bytewe #(
    .ADDR_WIDTH(ADDR_WIDTH)
  ) u_sram (
    .clk  (clk),
    .we   (mem_we),
    .addr (word_off[ADDR_WIDTH-1:0]),
    .wdata(src_dat),
    .rdata(mem_rdata)
  );

  // Responses decode straight from state flops so reset clears them at once.
  assign wb_ack_o = (state == RESP) && !err_q;
  assign wb_err_o = (state == RESP) &&  err_q;
  assign wb_dat_o = (wb_ack_o && !we_q) ? mem_rdata : '0;

endmodule

// File: tb/tb_wb_sram_slave.sv
// Self-checking bench: three responders (0, 3 and 5 wait states) on a shared bus, scoreboarded.
// Latency: checks response cycle, single-cycle termination, err decode, abort and reset.
// Backpressure: one transaction at a time, selected by per-instance cyc.
module tb_wb_sram_slave;

  logic        clk = 1'b0;
  logic        rst_i;
  logic [2:0]  cyc;
  logic        stb;
  logic        we;
  logic [31:0] adr;
  logic [3:0]  sel;
  logic [31:0] wdat;
  logic [2:0]  ack;
  logic [2:0]  err;
  logic [31:0] rdat [3];

  always #5 clk = ~clk;

  wb_sram_slave #(.ADDR_WIDTH(10), .BASE_ADDR(32'h0000_0000), .LATENCY(0)) u_l0 (
    .clk(clk), .rst_i(rst_i), .wb_cyc_i(cyc[0]), .wb_stb_i(stb), .wb_we_i(we),
    .wb_adr_i(adr), .wb_sel_i(sel), .wb_dat_i(wdat),
    .wb_dat_o(rdat[0]), .wb_ack_o(ack[0]), .wb_err_o(err[0]));

  wb_sram_slave #(.ADDR_WIDTH(6), .BASE_ADDR(32'h0000_1000), .LATENCY(3)) u_l3 (
    .clk(clk), .rst_i(rst_i), .wb_cyc_i(cyc[1]), .wb_stb_i(stb), .wb_we_i(we),
    .wb_adr_i(adr), .wb_sel_i(sel), .wb_dat_i(wdat),
    .wb_dat_o(rdat[1]), .wb_ack_o(ack[1]), .wb_err_o(err[1]));

  wb_sram_slave #(.ADDR_WIDTH(10), .BASE_ADDR(32'h0000_0000), .LATENCY(5)) u_l5 (
    .clk(clk), .rst_i(rst_i), .wb_cyc_i(cyc[2]), .wb_stb_i(stb), .wb_we_i(we),
    .wb_adr_i(adr), .wb_sel_i(sel), .wb_dat_i(wdat),
    .wb_dat_o(rdat[2]), .wb_ack_o(ack[2]), .wb_err_o(err[2]));

  function automatic int lat_of(input int i);
    case (i)
      0:       return 0;
      1:       return 3;
      default: return 5;
    endcase
  endfunction

  function automatic longint base_of(input int i);
    return (i == 1) ? 64'h1000 : 64'h0;
  endfunction

  function automatic longint size_of(input int i);
    return (i == 1) ? 64'd256 : 64'd4096;
  endfunction

  function automatic bit exp_err(input int i, input logic [31:0] a);
    longint la;
    la = longint'({32'h0, a});
    return (a[1:0] != 2'b00) || (la < base_of(i)) || (la >= base_of(i) + size_of(i));
  endfunction

  int checks = 0;
  int passed = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got === exp) passed++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  typedef struct {
    string       tag;
    bit          is_rd;
    bit          err;
    logic [31:0] dat;
    int          lat;
  } exp_t;

  exp_t        sb [$];
  logic [31:0] mdl [int];

  // Push the expected response, run the bus cycle, then pop and compare.
  task automatic xact(input int i, input bit w, input logic [31:0] a,
                      input logic [3:0] s, input logic [31:0] d, input string tag);
    exp_t        e;
    exp_t        r;
    int          n;
    bit          seen;
    int          key;
    logic [31:0] cur;
    e.tag   = tag;
    e.is_rd = !w;
    e.err   = exp_err(i, a);
    e.lat   = lat_of(i) + 1;
    e.dat   = 32'h0;
    key     = i * 65536 + int'(a[17:2]);
    if (!e.err) begin
      if (w) begin
        cur = mdl.exists(key) ? mdl[key] : 32'hxxxx_xxxx;
        for (int b = 0; b < 4; b++) if (s[b]) cur[8*b +: 8] = d[8*b +: 8];
        mdl[key] = cur;
      end else begin
        e.dat = mdl[key];
      end
    end
    sb.push_back(e);

    @(negedge clk);
    cyc[i] = 1'b1; stb = 1'b1; we = w; adr = a; sel = s; wdat = d;
    n = 0;
    seen = 1'b0;
    while (!seen && n < 30) begin
      @(negedge clk);
      n++;
      seen = ack[i] | err[i];
    end
    r = sb.pop_front();
    check_eq({r.tag, "/responded"}, 32'(seen), 32'd1);
    if (seen) begin
      check_eq({r.tag, "/latency"}, n, r.lat);
      check_eq({r.tag, "/ack"}, 32'(ack[i]), 32'(!r.err));
      check_eq({r.tag, "/err"}, 32'(err[i]), 32'(r.err));
      if (r.is_rd || r.err) check_eq({r.tag, "/dat"}, rdat[i], r.dat);
    end
    cyc[i] = 1'b0; stb = 1'b0; we = 1'b0;
    @(negedge clk);
    check_eq({r.tag, "/one_cycle"}, 32'({ack[i], err[i]}), 32'd0);
  endtask

  initial begin
    rst_i = 1'b1; cyc = 3'b000; stb = 1'b0; we = 1'b0;
    adr = 32'h0; sel = 4'h0; wdat = 32'h0;
    repeat (2) @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      check_eq("rst_ack", 32'(ack[i]), 32'd0);
      check_eq("rst_err", 32'(err[i]), 32'd0);
      check_eq("rst_dat", rdat[i], 32'h0);
    end
    rst_i = 1'b0;

    // Zero wait states: full word, byte lane, sel=0, errors, top word.
    xact(0, 1'b1, 32'h10, 4'hF, 32'hDEADBEEF, "l0_wr");
    xact(0, 1'b0, 32'h10, 4'hF, 32'h0,        "l0_rd");
    xact(0, 1'b1, 32'h10, 4'b0010, 32'h0000AA00, "l0_wr_lane");
    xact(0, 1'b0, 32'h10, 4'b0001, 32'h0,     "l0_rd_lane");
    xact(0, 1'b1, 32'h13, 4'hF, 32'h11111111, "l0_wr_misalign");
    xact(0, 1'b0, 32'h10, 4'hF, 32'h0,        "l0_rd_after_err");
    xact(0, 1'b0, 32'h1000, 4'hF, 32'h0,      "l0_rd_past_end");
    xact(0, 1'b1, 32'hFFC, 4'hF, 32'h55AA55AA, "l0_wr_top");
    xact(0, 1'b0, 32'hFFC, 4'hF, 32'h0,       "l0_rd_top");
    xact(0, 1'b1, 32'h10, 4'h0, 32'hFFFFFFFF, "l0_wr_sel0");
    xact(0, 1'b0, 32'h10, 4'hF, 32'h0,        "l0_rd_sel0");

    for (int k = 0; k < 6; k++)
      xact(0, 1'b1, 32'h100 + 32'(4 * k), 4'hF, $urandom, "l0_fill");
    for (int k = 0; k < 6; k++)
      xact(0, 1'b1, 32'h100 + 32'(4 * k), 4'($urandom_range(0, 15)), $urandom, "l0_part");
    for (int k = 0; k < 6; k++)
      xact(0, 1'b0, 32'h100 + 32'(4 * k), 4'hF, 32'h0, "l0_rd_rand");

    // Reset during the response cycle clears outputs without a clock edge.
    @(negedge clk);
    cyc[0] = 1'b1; stb = 1'b1; we = 1'b0; adr = 32'h10; sel = 4'hF;
    @(negedge clk);
    check_eq("rst_resp_pre_ack", 32'(ack[0]), 32'd1);
    check_eq("rst_resp_pre_dat", rdat[0], mdl[int'(16'h4)]);
    rst_i = 1'b1;
    #1;
    check_eq("rst_resp_ack", 32'(ack[0]), 32'd0);
    check_eq("rst_resp_dat", rdat[0], 32'h0);
    cyc[0] = 1'b0; stb = 1'b0;
    @(negedge clk);
    rst_i = 1'b0;

    // Three wait states, non-zero base.
    xact(1, 1'b1, 32'h1000, 4'hF, 32'h11112222, "l3_wr");
    xact(1, 1'b0, 32'h1000, 4'hF, 32'h0,        "l3_rd");
    xact(1, 1'b0, 32'h0FFC, 4'hF, 32'h0,        "l3_rd_below");
    xact(1, 1'b0, 32'h1100, 4'hF, 32'h0,        "l3_rd_past_end");
    xact(1, 1'b1, 32'h10FC, 4'hF, 32'h0BADF00D, "l3_wr_top");
    xact(1, 1'b0, 32'h10FC, 4'hF, 32'h0,        "l3_rd_top");

    // Reset while waiting: pending write is dropped, next access has full latency.
    @(negedge clk);
    cyc[1] = 1'b1; stb = 1'b1; we = 1'b1; adr = 32'h1000; sel = 4'hF; wdat = 32'hBAD0BAD0;
    @(negedge clk);
    check_eq("rst_wait_pre_ack", 32'(ack[1]), 32'd0);
    rst_i = 1'b1;
    #1;
    check_eq("rst_wait_ack", 32'(ack[1]), 32'd0);
    check_eq("rst_wait_err", 32'(err[1]), 32'd0);
    check_eq("rst_wait_dat", rdat[1], 32'h0);
    cyc[1] = 1'b0; stb = 1'b0; we = 1'b0;
    @(negedge clk);
    rst_i = 1'b0;
    xact(1, 1'b0, 32'h1000, 4'hF, 32'h0, "l3_rd_after_rst");

    // Five wait states: abort a write by dropping cyc mid-wait.
    xact(2, 1'b1, 32'h20, 4'hF, 32'hCAFEF00D, "l5_wr");
    @(negedge clk);
    cyc[2] = 1'b1; stb = 1'b1; we = 1'b1; adr = 32'h20; sel = 4'hF; wdat = 32'h12345678;
    repeat (2) begin
      @(negedge clk);
      check_eq("abort_quiet_wait", 32'({ack[2], err[2]}), 32'd0);
    end
    cyc[2] = 1'b0; stb = 1'b0; we = 1'b0;
    repeat (8) begin
      @(negedge clk);
      check_eq("abort_quiet_after", 32'({ack[2], err[2]}), 32'd0);
    end
    xact(2, 1'b0, 32'h20, 4'hF, 32'h0, "l5_rd_after_abort");

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
